packet_register_bank: RTL and testbench

- Sits directly downstream of the UART packetiser's receive path and upstream of its transmit path.
- Consumes received packet bytes addressed to LOCAL_ADDR and executes 32-bit register reads and writes.
- Returns one response packet per accepted request, with byte-level valid/ready handshake.
- Exposes the register contents to the rest of the design.

---
 rtl/packet_register_bank_if.sv | 39 +++
 rtl/packet_register_bank.sv | 202 ++++++++++++++++++++
 tb/tb_packet_register_bank.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_register_bank_if.sv
// +------------------------------------------------------------------------+
// | packet_register_bank_if                                                |
// | Byte-level request (rx) and response (tx) bus of packet_register_bank. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

interface packet_register_bank_if;
  logic [7:0] ipRxDestination;
  logic [7:0] ipRxSource;
  logic [7:0] ipRxLength;
  logic [7:0] ipRxData;
  logic       ipRxValid;

  logic [7:0] opTxDestination;
  logic [7:0] opTxSource;
  logic [7:0] opTxLength;
  logic [7:0] opTxData;
  logic       opTxSoP;
  logic       opTxEoP;
  logic       opTxValid;
  logic       ipTxReady;

  modport master (
    output ipRxDestination, ipRxSource, ipRxLength, ipRxData, ipRxValid,
    output ipTxReady,
    input  opTxDestination, opTxSource, opTxLength, opTxData,
    input  opTxSoP, opTxEoP, opTxValid
  );

  modport slave (
    input  ipRxDestination, ipRxSource, ipRxLength, ipRxData, ipRxValid,
    input  ipTxReady,
    output opTxDestination, opTxSource, opTxLength, opTxData,
    output opTxSoP, opTxEoP, opTxValid
  );
endinterface

`default_nettype wire

// File: rtl/packet_register_bank.sv
// +------------------------------------------------------------------------+
// | packet_register_bank                                                   |
// | Packet-driven bank of 32-bit registers: executes reads/writes from     |
// | received packets and streams one response packet per request.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module packet_register_bank #(
  parameter logic [7:0] LOCAL_ADDR = 8'h01,
  parameter int         NUM_REGS   = 8
) (
  input  wire logic                    ipClk,
  input  wire logic                    ipReset,
  packet_register_bank_if.slave        bus,
  output logic [32*NUM_REGS-1:0]       opRegisters,
  output logic [7:0]                   opDropCount
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COLLECT = 2'd1;
  localparam logic [1:0] c_DISCARD = 2'd2;
  localparam logic [1:0] c_RESPOND = 2'd3;

  localparam logic [8:0] c_NUM_REGS = 9'(NUM_REGS);
  localparam logic [7:0] c_ERR_TAG  = 8'hEE;

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [7:0]  r_byteCount;
  logic [7:0]  w_countNext;
  logic        w_firstByte;
  logic        w_lastByte;
  logic        w_forUs;
  logic        w_rxAddrInRange;
  logic        w_addrInRange;

  logic [7:0]  r_source;
  logic [7:0]  r_length;
  logic [7:0]  r_addr;
  logic [31:0] r_assembly;
  logic        r_isError;
  logic [2:0]  r_txIdx;
  logic        w_txFire;
  logic        w_txLast;
  logic        w_writeEn;
  logic [31:0] w_writeData;
  logic [31:0] w_readValue;

  // Framing is derived purely from the byte counter, independent of the FSM.
  assign w_countNext     = r_byteCount + 8'd1;
  assign w_firstByte     = bus.ipRxValid && (r_byteCount == 8'd0);
  assign w_lastByte      = bus.ipRxValid && (w_countNext == bus.ipRxLength);
  assign w_forUs         = (bus.ipRxDestination == LOCAL_ADDR);
  assign w_rxAddrInRange = ({1'b0, bus.ipRxData} < c_NUM_REGS);
  assign w_addrInRange   = ({1'b0, r_addr} < c_NUM_REGS);

  assign w_txFire    = (r_state == c_RESPOND) && bus.ipTxReady;
  assign w_txLast    = r_isError ? (r_txIdx == 3'd1) : (r_txIdx == 3'd4);
  assign w_writeEn   = (r_state == c_COLLECT) && w_lastByte &&
                       (r_length == 8'd5) && w_addrInRange;
  assign w_writeData = {r_assembly[23:0], bus.ipRxData};

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_firstByte) begin
          if (w_forUs) begin
            w_nextState = (bus.ipRxLength == 8'd1) ? c_RESPOND : c_COLLECT;
          end else if (!w_lastByte) begin
            w_nextState = c_DISCARD;
          end
        end
      end
      c_COLLECT: begin
        if (w_lastByte) begin
          w_nextState = c_RESPOND;
        end
      end
      c_DISCARD: begin
        if (w_lastByte) begin
          w_nextState = c_IDLE;
        end
      end
      c_RESPOND: begin
        if (w_txFire && w_txLast) begin
          w_nextState = c_IDLE;
        end
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    bus.opTxValid       = 1'b0;
    bus.opTxDestination = 8'd0;
    bus.opTxSource      = 8'd0;
    bus.opTxLength      = 8'd0;
    bus.opTxData        = 8'd0;
    bus.opTxSoP         = 1'b0;
    bus.opTxEoP         = 1'b0;
    if (r_state == c_RESPOND) begin
      bus.opTxValid       = 1'b1;
      bus.opTxDestination = r_source;
      bus.opTxSource      = LOCAL_ADDR;
      bus.opTxLength      = r_isError ? 8'd2 : 8'd5;
      bus.opTxSoP         = (r_txIdx == 3'd0);
      bus.opTxEoP         = w_txLast;
      case (r_txIdx)
        3'd0:    bus.opTxData = r_isError ? c_ERR_TAG : r_addr;
        3'd1:    bus.opTxData = r_isError ? r_addr : w_readValue[31:24];
        3'd2:    bus.opTxData = w_readValue[23:16];
        3'd3:    bus.opTxData = w_readValue[15:8];
        3'd4:    bus.opTxData = w_readValue[7:0];
        default: bus.opTxData = 8'd0;
      endcase
    end
  end

  always_comb begin
    w_readValue = 32'd0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_addr == 8'(k)) begin
        w_readValue = opRegisters[32*k +: 32];
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      r_byteCount <= 8'd0;
      r_source    <= 8'd0;
      r_length    <= 8'd0;
      r_addr      <= 8'd0;
      r_assembly  <= 32'd0;
      r_isError   <= 1'b0;
      r_txIdx     <= 3'd0;
      opDropCount <= 8'd0;
    end else begin
      if (bus.ipRxValid) begin
        r_byteCount <= (w_countNext == bus.ipRxLength) ? 8'd0 : w_countNext;
      end

      case (r_state)
        c_IDLE: begin
          if (w_firstByte && w_forUs) begin
            r_source  <= bus.ipRxSource;
            r_length  <= bus.ipRxLength;
            r_addr    <= bus.ipRxData;
            r_txIdx   <= 3'd0;
            // Only a single-byte read answers straight away; decided here.
            r_isError <= !w_rxAddrInRange;
          end
        end
        c_COLLECT: begin
          if (bus.ipRxValid) begin
            r_assembly <= w_writeData;
          end
          if (w_lastByte) begin
            r_isError <= !((r_length == 8'd5) && w_addrInRange);
            r_txIdx   <= 3'd0;
          end
        end
        c_RESPOND: begin
          if (w_txFire) begin
            r_txIdx <= w_txLast ? 3'd0 : r_txIdx + 3'd1;
          end
          if (w_firstByte && (opDropCount != 8'hFF)) begin
            opDropCount <= opDropCount + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [31:0] r_value;

    always_ff @(posedge ipClk) begin
      if (ipReset) begin
        r_value <= 32'd0;
      end else if (w_writeEn && (r_addr == 8'(k))) begin
        r_value <= w_writeData;
      end
    end

    assign opRegisters[32*k +: 32] = r_value;
  end

endmodule

`default_nettype wire

// File: tb/tb_packet_register_bank.sv
// +------------------------------------------------------------------------+
// | tb_packet_register_bank                                                |
// | Table-driven request vectors with a response-byte scoreboard.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_packet_register_bank;
  localparam int         NUM_REGS = 8;
  localparam logic [7:0] LOCAL    = 8'h01;
  localparam int         NVEC     = 11;

  logic ipClk = 1'b0;
  logic ipReset;
  always #5 ipClk = ~ipClk;

  packet_register_bank_if busIf();
  logic [32*NUM_REGS-1:0] opRegisters;
  logic [7:0]             opDropCount;

  packet_register_bank #(
    .LOCAL_ADDR (LOCAL),
    .NUM_REGS   (NUM_REGS)
  ) dut (
    .ipClk       (ipClk),
    .ipReset     (ipReset),
    .bus         (busIf.slave),
    .opRegisters (opRegisters),
    .opDropCount (opDropCount)
  );

  typedef struct packed {
    logic [7:0] dest;
    logic [7:0] src;
    logic [7:0] len;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } txEntry_t;

  typedef struct packed {
    logic [7:0]  dest;
    logic [7:0]  src;
    logic [7:0]  len;
    logic [39:0] bytes;
    logic [7:0]  respLen;
    logic [39:0] resp;
  } vec_t;

  txEntry_t    sb[$];
  vec_t        vecs [NVEC];
  logic [31:0] model [NUM_REGS];
  int          total = 0;
  int          bad   = 0;

  // Scoreboard side: every transferred byte must match the next expected one.
  always @(negedge ipClk) begin
    if (!ipReset && busIf.opTxValid && busIf.ipTxReady) begin
      txEntry_t act;
      txEntry_t exp;
      act = '{busIf.opTxDestination, busIf.opTxSource, busIf.opTxLength,
              busIf.opTxData, busIf.opTxSoP, busIf.opTxEoP};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL txUnexpected act=%h req=none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL txByte act=%h req=%h (dest,src,len,data,sop,eop)", act, exp);
        end
      end
    end
  end

  task automatic pushResp(input logic [7:0] src, input logic [7:0] len, input logic [39:0] bytes);
    txEntry_t e;
    for (int i = 0; i < int'(len); i++) begin
      e.dest = src;
      e.src  = LOCAL;
      e.len  = len;
      e.data = bytes[39-8*i -: 8];
      e.sop  = (i == 0);
      e.eop  = (i == int'(len) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic sendPacket(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] len,
                            input logic [39:0] bytes, input logic expectResp);
    busIf.ipRxDestination = dest;
    busIf.ipRxSource      = src;
    busIf.ipRxLength      = len;
    for (int i = 0; i < int'(len); i++) begin
      @(posedge ipClk); #1;
      busIf.ipRxValid = 1'b1;
      busIf.ipRxData  = bytes[39-8*i -: 8];
    end
    @(posedge ipClk); #1;
    busIf.ipRxValid = 1'b0;
    total++;
    if (busIf.opTxValid !== expectResp) begin
      bad++;
      $display("FAIL txValidStart act=%b req=%b", busIf.opTxValid, expectResp);
    end
  endtask

  task automatic waitIdle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busIf.opTxValid) begin
        done = 1'b1;
        break;
      end
      @(posedge ipClk); #1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout act=pending%0d req=drained", tag, sb.size());
    end
  endtask

  task automatic checkRegs(input string tag);
    logic [32*NUM_REGS-1:0] exp;
    for (int k = 0; k < NUM_REGS; k++) exp[32*k +: 32] = model[k];
    total++;
    if (opRegisters !== exp) begin
      bad++;
      $display("FAIL %s regs act=%h req=%h", tag, opRegisters, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    logic [59:0] act;
    act = {busIf.opTxDestination, busIf.opTxSource, busIf.opTxLength, busIf.opTxData,
           busIf.opTxSoP, busIf.opTxEoP, busIf.opTxValid, 1'b0, opDropCount, 16'h0};
    total++;
    if (act !== 60'd0 || opRegisters !== '0) begin
      bad++;
      $display("FAIL %s resetState act=%h regs=%h req=0", tag, act, opRegisters);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h01, 8'h07, 8'd1, 40'h03_00000000, 8'd5, 40'h03_00000000};
    vecs[1]  = '{8'h01, 8'h07, 8'd5, 40'h02_DEADBEEF, 8'd5, 40'h02_DEADBEEF};
    vecs[2]  = '{8'h01, 8'h07, 8'd5, 40'h09_11223344, 8'd2, 40'hEE_09_000000};
    vecs[3]  = '{8'h01, 8'h07, 8'd3, 40'h04_AABB_0000, 8'd2, 40'hEE_04_000000};
    vecs[4]  = '{8'h05, 8'h07, 8'd5, 40'h02_00000000, 8'd0, 40'h0};
    vecs[5]  = '{8'h01, 8'h07, 8'd1, 40'h02_00000000, 8'd5, 40'h02_DEADBEEF};
    vecs[6]  = '{8'h01, 8'h07, 8'd1, 40'h08_00000000, 8'd2, 40'hEE_08_000000};
    vecs[7]  = '{8'h01, 8'h0A, 8'd5, 40'h07_12345678, 8'd5, 40'h07_12345678};
    vecs[8]  = '{8'h05, 8'h07, 8'd1, 40'h00_00000000, 8'd0, 40'h0};
    vecs[9]  = '{8'h01, 8'h33, 8'd1, 40'h07_00000000, 8'd5, 40'h07_12345678};
    vecs[10] = '{8'h01, 8'h42, 8'd5, 40'h00_A5C30F96, 8'd5, 40'h00_A5C30F96};
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'd0;

    ipReset               = 1'b1;
    busIf.ipRxDestination = 8'd0;
    busIf.ipRxSource      = 8'd0;
    busIf.ipRxLength      = 8'd0;
    busIf.ipRxData        = 8'd0;
    busIf.ipRxValid       = 1'b0;
    busIf.ipTxReady       = 1'b1;
    repeat (3) @(posedge ipClk);
    #1;
    checkAllZero("initial");
    ipReset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].respLen != 8'd0) pushResp(vecs[v].src, vecs[v].respLen, vecs[v].resp);
      sendPacket(vecs[v].dest, vecs[v].src, vecs[v].len, vecs[v].bytes, vecs[v].respLen != 8'd0);
      waitIdle($sformatf("vec%0d", v));
      if (vecs[v].dest == LOCAL && vecs[v].len == 8'd5 && vecs[v].bytes[39:32] < 8'(NUM_REGS))
        model[vecs[v].bytes[34:32]] = vecs[v].bytes[31:0];
      checkRegs($sformatf("vec%0d", v));
    end

    // Backpressure mid-response, with a colliding request that must be dropped.
    busIf.ipTxReady = 1'b0;
    pushResp(8'h07, 8'd5, 40'h02_DEADBEEF);
    sendPacket(8'h01, 8'h07, 8'd1, 40'h02_00000000, 1'b1);
    busIf.ipTxReady = 1'b1;
    @(posedge ipClk); #1;
    @(posedge ipClk); #1;
    busIf.ipTxReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (busIf.opTxData !== 8'hAD || busIf.opTxValid !== 1'b1 || busIf.opTxSoP !== 1'b0) begin
        bad++;
        $display("FAIL holdByte cyc%0d act=%h/%b req=ad/1", i, busIf.opTxData, busIf.opTxValid);
      end
      if (i == 3) begin
        busIf.ipRxDestination = 8'h01;
        busIf.ipRxSource      = 8'h09;
        busIf.ipRxLength      = 8'd1;
        busIf.ipRxData        = 8'h00;
        busIf.ipRxValid       = 1'b1;
      end else begin
        busIf.ipRxValid = 1'b0;
      end
      @(posedge ipClk); #1;
    end
    total++;
    if (opDropCount !== 8'd1) begin
      bad++;
      $display("FAIL dropCount act=%0d req=1", opDropCount);
    end
    busIf.ipTxReady = 1'b1;
    waitIdle("backpressure");
    checkRegs("backpressure");

    // Reset after two response bytes, then a fresh read from SoP.
    busIf.ipTxReady = 1'b0;
    pushResp(8'h07, 8'd5, 40'h02_DEADBEEF);
    sendPacket(8'h01, 8'h07, 8'd1, 40'h02_00000000, 1'b1);
    busIf.ipTxReady = 1'b1;
    @(posedge ipClk); #1;
    @(posedge ipClk); #1;
    busIf.ipTxReady = 1'b0;
    ipReset = 1'b1;
    @(posedge ipClk); #1;
    checkAllZero("midReset");
    ipReset = 1'b0;
    sb.delete();
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'd0;
    busIf.ipTxReady = 1'b1;
    pushResp(8'h07, 8'd5, 40'h02_00000000);
    sendPacket(8'h01, 8'h07, 8'd1, 40'h02_00000000, 1'b1);
    waitIdle("afterReset");
    checkRegs("afterReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
